// File: rtl/mci_mcu_sram_ctrl.sv
// MCU SRAM request-channel controller: turns cif-style requests into single-port
// SRAM accesses, with RMW for partial strobes and protected/exec region checking.
module mci_mcu_sram_ctrl #(
    parameter  int MCU_SRAM_SIZE_KB = 1024,
    parameter  int DATA_WIDTH       = 32,
    localparam int SRAM_ADDR_WIDTH  = $clog2(MCU_SRAM_SIZE_KB*1024/(DATA_WIDTH/8))
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       req_dv,
    input  logic [31:0]                req_addr,
    input  logic                       req_write,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    input  logic [DATA_WIDTH/8-1:0]    req_wstrb,
    input  logic                       mcu_lsu_req,
    input  logic                       mcu_req,
    input  logic                       clp_req,
    input  logic [SRAM_ADDR_WIDTH-1:0] exec_region_base,

    output logic                       resp_hold,
    output logic                       resp_error,
    output logic [DATA_WIDTH-1:0]      resp_rdata,

    output logic                       sram_cs,
    output logic                       sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0]      sram_wdata,
    input  logic [DATA_WIDTH-1:0]      sram_rdata
);

    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        WR,
        RD,
        RD_DATA,
        RMW_RD,
        RMW_MERGE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [SRAM_ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [BYTES-1:0]           r_wstrb;

    logic [SRAM_ADDR_WIDTH-1:0] w_word;
    logic                       w_allowed;
    logic                       w_strb_full;
    logic                       w_strb_none;
    logic                       w_accept;
    logic [DATA_WIDTH-1:0]      w_merged;
    logic                       w_unused_addr;

    // Out-of-range address bits are the decoder's concern; they are deliberately dropped.
    assign w_word        = req_addr[SRAM_ADDR_WIDTH+1:2];
    assign w_unused_addr = ^{req_addr[31:SRAM_ADDR_WIDTH+2], req_addr[1:0]};

    // Protected region (below exec base) is LSU-only; exec region admits any MCU or Caliptra user.
    assign w_allowed   = (w_word < exec_region_base) ? mcu_lsu_req : (mcu_req | clp_req);
    assign w_strb_full = &req_wstrb;
    assign w_strb_none = ~|req_wstrb;
    assign w_accept    = (r_state == IDLE) && req_dv;

    for (genvar i = 0; i < BYTES; i++) begin : g_merge
        assign w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : sram_rdata[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= w_word;
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
            end
        end
    end

    assign sram_addr = r_addr;

    // Response fields are forced to zero unless this is the completion cycle (dv=1, hold=0).
    always_comb begin
        w_next     = r_state;
        resp_hold  = 1'b0;
        resp_error = 1'b0;
        resp_rdata = '0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = r_wdata;
        case (r_state)
            IDLE: begin
                if (req_dv) begin
                    resp_hold = 1'b1;
                    if (!w_allowed)                   w_next = ERR;
                    else if (!req_write)              w_next = RD;
                    else if (w_strb_full || w_strb_none) w_next = WR;
                    else                              w_next = RMW_RD;
                end
            end
            ERR: begin
                resp_error = req_dv;
                w_next     = IDLE;
            end
            WR: begin
                // An all-zero strobe write completes without touching the macro.
                sram_cs = |r_wstrb;
                sram_we = |r_wstrb;
                w_next  = IDLE;
            end
            RD: begin
                sram_cs   = 1'b1;
                resp_hold = req_dv;
                w_next    = RD_DATA;
            end
            RD_DATA: begin
                resp_rdata = req_dv ? sram_rdata : '0;
                w_next     = IDLE;
            end
            RMW_RD: begin
                sram_cs   = 1'b1;
                resp_hold = req_dv;
                w_next    = RMW_MERGE;
            end
            RMW_MERGE: begin
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_wdata = w_merged;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    a_no_cs_idle_err: assert property (@(posedge clk) disable iff (rst)
        ((r_state == IDLE) || (r_state == ERR)) |-> !sram_cs);
    a_err_no_hold: assert property (@(posedge clk) disable iff (rst)
        resp_error |-> !resp_hold);

endmodule

// File: tb/tb_mci_mcu_sram_ctrl.sv
// Scoreboard bench for mci_mcu_sram_ctrl: driver pushes expected responses from a
// word-level memory model, a negedge monitor pops and compares at each completion.
module tb_mci_mcu_sram_ctrl;

    localparam int AW    = $clog2(1024*1024/4);
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_dv;
    logic [31:0]   req_addr;
    logic          req_write;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic          mcu_lsu_req, mcu_req, clp_req;
    logic [AW-1:0] exec_region_base;
    logic          resp_hold, resp_error;
    logic [31:0]   resp_rdata;
    logic          sram_cs, sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = 32'h0;

    mci_mcu_sram_ctrl dut (
        .clk(clk), .rst(rst),
        .req_dv(req_dv), .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .mcu_lsu_req(mcu_lsu_req), .mcu_req(mcu_req), .clp_req(clp_req),
        .exec_region_base(exec_region_base),
        .resp_hold(resp_hold), .resp_error(resp_error), .resp_rdata(resp_rdata),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM macro: one-cycle read latency
    logic [31:0] sram_mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) sram_mem[i] = 32'h0;
    always @(posedge clk) begin
        if (sram_cs && sram_we)  sram_mem[sram_addr] <= sram_wdata;
        if (sram_cs && !sram_we) sram_rdata <= sram_mem[sram_addr];
    end

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          cs;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [int];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    endfunction

    // Monitor
    int   m_cyc = 0;
    int   m_cs  = 0;
    exp_t m_e;
    always @(negedge clk) begin
        if (rst) begin
            m_cyc = 0;
            m_cs  = 0;
        end else if (req_dv) begin
            m_cyc++;
            if (sram_cs) m_cs++;
            if (resp_hold) begin
                check("quiet_err_while_hold", {31'b0, resp_error}, 32'h0);
                check("quiet_rdata_while_hold", resp_rdata, 32'h0);
            end else begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_completion: got completion expected none at %0t", $time);
                end else begin
                    m_e = exp_q.pop_front();
                    check("error", {31'b0, resp_error}, {31'b0, m_e.err});
                    check("rdata", resp_rdata, m_e.rdata);
                    check("latency", m_cyc, m_e.lat);
                    check("sram_cs_cycles", m_cs, m_e.cs);
                end
                m_cyc = 0;
                m_cs  = 0;
            end
        end
    end

    // Driver: computes the expected response from the access rules, then runs the handshake.
    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic lsu, input logic mcu,
                          input logic clp, input logic [AW-1:0] base);
        exp_t        e;
        int          w;
        logic        allowed;
        logic [31:0] nw;
        bit          done;
        w       = int'((addr >> 2) & (DEPTH - 1));
        allowed = (w < int'(base)) ? lsu : (mcu || clp);
        e.err   = 1'b0;
        e.rdata = 32'h0;
        if (!allowed) begin
            e.err = 1'b1; e.lat = 2; e.cs = 0;
        end else if (!wr) begin
            e.lat = 3; e.cs = 1; e.rdata = ref_rd(w);
        end else if (ws == 4'h0) begin
            e.lat = 2; e.cs = 0;
        end else if (ws == 4'hF) begin
            e.lat = 2; e.cs = 1; ref_mem[w] = wd;
        end else begin
            e.lat = 3; e.cs = 2;
            nw = ref_rd(w);
            for (int b = 0; b < 4; b++)
                if (ws[b]) nw[8*b +: 8] = wd[8*b +: 8];
            ref_mem[w] = nw;
        end
        exp_q.push_back(e);
        req_addr = addr; req_write = wr; req_wdata = wd; req_wstrb = ws;
        mcu_lsu_req = lsu; mcu_req = mcu; clp_req = clp; exec_region_base = base;
        req_dv = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (!resp_hold) done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: got no completion expected one within 8 cycles at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        req_dv = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Reset lands while the RMW write is on the SRAM bus; that write must be lost.
    task automatic reset_in_rmw();
        req_addr = 32'h800; req_write = 1'b1; req_wdata = 32'hAAAA5555; req_wstrb = 4'h1;
        mcu_lsu_req = 1'b0; mcu_req = 1'b1; clp_req = 1'b0; exec_region_base = 18'h100;
        req_dv = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rmw_merge_cs", {31'b0, sram_cs}, 32'h1);
        check("rmw_merge_we", {31'b0, sram_we}, 32'h1);
        rst = 1'b1;
        req_dv = 1'b0;
        #1;
        check("rst_cs", {31'b0, sram_cs}, 32'h0);
        check("rst_we", {31'b0, sram_we}, 32'h0);
        check("rst_addr", {14'b0, sram_addr}, 32'h0);
        check("rst_wdata", sram_wdata, 32'h0);
        check("rst_hold", {31'b0, resp_hold}, 32'h0);
        check("rst_error", {31'b0, resp_error}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0]   r_addr, r_wd;
    logic [AW-1:0] r_base;
    int            r_w;

    initial begin
        rst = 1'b1; req_dv = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
        req_wstrb = '0; mcu_lsu_req = 1'b0; mcu_req = 1'b0; clp_req = 1'b0;
        exec_region_base = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs", {31'b0, sram_cs}, 32'h0);
        check("reset_we", {31'b0, sram_we}, 32'h0);
        check("reset_addr", {14'b0, sram_addr}, 32'h0);
        check("reset_wdata", sram_wdata, 32'h0);
        check("reset_hold", {31'b0, resp_hold}, 32'h0);
        check("reset_error", {31'b0, resp_error}, 32'h0);
        check("reset_rdata", resp_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_req(32'h800, 1, 32'hDEADBEEF, 4'hF, 0, 1, 0, 18'h100);
        do_req(32'h800, 0, 32'h0,        4'h0, 0, 1, 0, 18'h100);
        do_req(32'h800, 1, 32'h00001234, 4'h3, 0, 1, 0, 18'h100);
        do_req(32'h800, 0, 32'h0,        4'h0, 0, 1, 0, 18'h100);
        idle_cycle();
        do_req(32'h800, 0, 32'h0,        4'h0, 0, 0, 0, 18'h100);
        do_req(32'h040, 1, 32'hCAFEF00D, 4'hF, 0, 0, 1, 18'h100);
        do_req(32'h040, 1, 32'hCAFEF00D, 4'hF, 1, 1, 0, 18'h100);
        do_req(32'h040, 0, 32'h0,        4'h0, 1, 1, 0, 18'h100);
        do_req(32'h800, 1, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 18'h100);
        do_req(32'h040, 0, 32'h0,        4'h0, 1, 0, 0, 18'h000);
        do_req(32'h040, 0, 32'h0,        4'h0, 0, 1, 0, 18'h000);
        do_req(32'h800, 0, 32'h0,        4'h0, 0, 1, 1, 18'h3FFFF);
        do_req(32'h800, 0, 32'h0,        4'h0, 1, 0, 0, 18'h3FFFF);
        do_req(32'hFFF00802, 0, 32'h0,   4'h0, 0, 1, 0, 18'h100);
        idle_cycle();

        reset_in_rmw();
        do_req(32'h800, 0, 32'h0, 4'h0, 0, 1, 0, 18'h100);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       r_w = 32'h0F;
                1:       r_w = 32'h10;
                2:       r_w = 32'h200;
                default: r_w = int'($urandom_range(0, DEPTH - 1));
            endcase
            r_addr = (32'(r_w) << 2) | ($urandom & 32'hFFF00003);
            case ($urandom_range(0, 4))
                0:       r_base = 18'h0;
                1:       r_base = 18'h10;
                2:       r_base = 18'h100;
                3:       r_base = 18'h3FFFF;
                default: r_base = AW'($urandom);
            endcase
            r_wd = $urandom;
            do_req(r_addr, 1'($urandom), r_wd, 4'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), r_base);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        idle_cycle();
        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
